inst_rom_arbiter: RTL and testbench
===================================

# inst_rom_arbiter

Two-port arbiter that shares the single-port instruction ROM between the IF-stage fetch path and the MEM-stage data path (loads from code space and debug reads). It sits between the pipeline and `inst_rom`. It grants at most one ROM access per cycle under round-robin priority and registers the ROM output into per-port response registers. It raises a fetch stall request to `ctrl` whenever the fetch port is waiting.

## Interface
Parameters:
- `ADDR_W`, 32: address width, matching `InstAddrBus`.
- `DATA_W`, 32: instruction and data width, matching `InstBus`.
- `CNT_W`, 16: width of the conflict counter.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `f_req`  in  1  fetch request.
- `f_addr`  in  ADDR_W  fetch byte address.
- `f_flush`  in  1  branch/exception flush; cancels fetch for the current cycle.
- `f_gnt`  out  1  fetch granted this cycle (combinational).
- `f_rvalid`  out  1  fetch response valid (registered).
- `f_rdata`  out  DATA_W  fetch response data.
- `d_req`  in  1  data request.
- `d_addr`  in  ADDR_W  data byte address.
- `d_gnt`  out  1  data granted this cycle (combinational).
- `d_rvalid`  out  1  data response valid (registered).
- `d_rdata`  out  DATA_W  data response data.
- `d_err`  out  1  misaligned data access; qualified by `d_rvalid`.
- `rom_ce`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr`  out  ADDR_W  ROM byte address.
- `rom_inst`  in  DATA_W  combinational ROM read data.
- `stallreq_if`  out  1  fetch stall request to `ctrl`; equals `f_req & ~f_gnt`.
- `conflict_cnt`  out  CNT_W  saturating count of cycles in which both ports requested.

## Operation
- **Effective requests:** `fe = f_req & ~f_flush`; `de = d_req & ~d_addr[1:0]_nonzero`.
- **Misaligned data access:** a `d_req` with `d_addr[1:0] != 0` is granted immediately, even if fetch is also granted that cycle. It performs no ROM access. Next cycle: `d_rvalid=1`, `d_err=1`, `d_rdata=ZeroWord`.
- **Arbitration:**
  - Only `fe` set: fetch wins.
  - Only `de` set: data wins.
  - Both set: the port that did not win the last contested ROM grant wins.
- **`last` register:** 1 bit, updated only on a contested grant. Reset value is "data", so fetch wins the first contest.
- **ROM drive:** on a grant, `rom_ce=ChipEnable` and `rom_addr` is the winner's address. With no ROM grant, `rom_ce=ChipDisable` and `rom_addr=ZeroWord`.
- **Response capture:** at the clock edge, `rom_inst` is captured into the winner's `rdata` register and that port's `rvalid` is set for exactly one cycle.
- **Data hold:** `f_rdata`/`d_rdata` hold their value until that port's next response.
- **Requester rule:** `req` and `addr` must be held stable until `gnt`. The arbiter does not store requests.
- **Flush:**
  - `f_flush` forces `f_gnt=0` in the same cycle.
  - An `f_rvalid` already due in the flush cycle is still presented; IF discards it.
  - A data request may be granted in the flush cycle.
- **Conflict counter:** `conflict_cnt` increments in every cycle where `f_req & d_req` (raw requests), saturating at all-ones.
- **Reset values:** `f_rvalid=0`, `d_rvalid=0`, `d_err=0`, `f_rdata=0`, `d_rdata=0`, `last`=data, `conflict_cnt=0`.
- **Reset mid-operation:** any response due next cycle is dropped. All outputs go to their reset values asynchronously.

## Timing
- Grant and ROM access happen in cycle t; the response appears in cycle t+1 (latency 1).
- Throughput is one ROM access per cycle.
- Under continuous contention, each port gets a grant every 2 cycles, so maximum wait is 1 cycle.
- `stallreq_if` is combinational in the same cycle as the lost arbitration.
- `f_gnt`, `d_gnt`, `rom_ce` and `rom_addr` are combinational from request inputs and `last`. There is no combinational path from `rom_inst` to any output.

## Structure
- `defines.v` provides `ZeroWord`, `ChipEnable`, `ChipDisable`, `InstAddrBus`, `InstBus`.
- Add to `defines.v`: `PortFetch`/`PortData` encodings for `last`, and `StallIF`.
- Sub-module `rr_arb2` contains the 2-way round-robin arbiter: inputs `req[1:0]`, state `last`, output one-hot `gnt[1:0]`.
- The top level holds the ROM mux, response registers, misalignment path and counter.
- Target size is about 150–250 lines of RTL.

## Test plan
- **Reset:** hold `rst_n=0` with both requests active → all outputs 0, `rom_ce=ChipDisable`. Release → first contested cycle grants fetch.
- **Solo fetch:** `f_req=1`, `f_addr=0x00000004`, ROM word 1 = `0x34011100` → `f_gnt=1`, `rom_addr=0x4` in cycle t. In t+1: `f_rvalid=1`, `f_rdata=0x34011100`.
- **Contention:** both request for 6 cycles → grants alternate F,D,F,D,F,D; `stallreq_if` high on D cycles; `conflict_cnt=6`.
- **Flush:** `f_flush=1` with `f_req=1` and `d_req=1` at `0x8` → `d_gnt=1`, `f_gnt=0`; next cycle `f_rvalid=0`, `d_rvalid=1`.
- **Misaligned:** `d_addr=0x00000006` while fetch requests `0x10` → both granted, `rom_addr=0x10`. Next cycle: `d_err=1`, `d_rdata=0`, `f_rvalid=1`.
- **Async reset mid-op:** assert `rst_n=0` between a grant edge and the next edge → `f_rvalid` drops immediately; counter cleared.

Source files
------------

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared encodings for the instruction-ROM arbiter: chip-enable levels,
// port identifiers held in the round-robin state, and the IF stall level.
package inst_rom_arbiter_pkg;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic PORT_FETCH   = 1'b0;
    localparam logic PORT_DATA    = 1'b1;

    localparam logic STALL_IF     = 1'b1;

    localparam int   REQ_FETCH    = 0;
    localparam int   REQ_DATA     = 1;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a contest goes to the port that did not
// win the previous contest, recorded in `last`.
module rr_arb2
    import inst_rom_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // one-hot grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_DATA) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between IF fetch and MEM data
// reads; one ROM access per cycle, responses registered one cycle later.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq_if,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              fe_s;
    logic              de_s;
    logic              mis_s;
    logic [1:0]        gnt_s;

    logic              last_q,     last_d;
    logic              f_rvalid_q, f_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q,  f_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              d_err_q,    d_err_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    // effective requests; requests are masked while in reset so nothing is granted
    always_comb begin
        mis_s = rst_n & d_req &  is_misaligned(d_addr[1:0]);
        de_s  = rst_n & d_req & ~is_misaligned(d_addr[1:0]);
        fe_s  = rst_n & f_req & ~f_flush;
    end

    rr_arb2 u_rr_arb2 (
        .req  ({de_s, fe_s}),
        .last (last_q),
        .gnt  (gnt_s)
    );

    // ROM drive and handshake outputs
    always_comb begin
        if (gnt_s[REQ_FETCH]) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = f_addr;
        end else if (gnt_s[REQ_DATA]) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = d_addr;
        end else begin
            rom_ce   = CHIP_DISABLE;
            rom_addr = {ADDR_W{1'b0}};
        end
        f_gnt       = gnt_s[REQ_FETCH];
        // misaligned data is answered without touching the ROM
        d_gnt       = gnt_s[REQ_DATA] | mis_s;
        stallreq_if = (rst_n & f_req & ~gnt_s[REQ_FETCH]) ? STALL_IF : ~STALL_IF;
    end

    // next-state for round-robin state, responses and conflict counter
    always_comb begin
        if (fe_s & de_s) begin
            last_d = gnt_s[REQ_FETCH] ? PORT_FETCH : PORT_DATA;
        end else begin
            last_d = last_q;
        end

        f_rvalid_d = gnt_s[REQ_FETCH];
        if (gnt_s[REQ_FETCH]) begin
            f_rdata_d = rom_inst;
        end else begin
            f_rdata_d = f_rdata_q;
        end

        d_rvalid_d = gnt_s[REQ_DATA] | mis_s;
        d_err_d    = mis_s;
        if (gnt_s[REQ_DATA]) begin
            d_rdata_d = rom_inst;
        end else if (mis_s) begin
            d_rdata_d = {DATA_W{1'b0}};
        end else begin
            d_rdata_d = d_rdata_q;
        end

        // raw requests count, even when flushed or misaligned
        if (f_req & d_req & ~(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= PORT_DATA;
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= {DATA_W{1'b0}};
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= {DATA_W{1'b0}};
            d_err_q    <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            last_q     <= last_d;
            f_rvalid_q <= f_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign f_rvalid     = f_rvalid_q;
    assign f_rdata      = f_rdata_q;
    assign d_rvalid     = d_rvalid_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomised and directed bench for inst_rom_arbiter against a per-cycle
// behavioural model of grants, responses and the conflict counter.
module tb_inst_rom_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          f_req, f_flush, f_gnt, f_rvalid;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_gnt, d_rvalid, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;
    logic          stallreq_if;
    logic [CW-1:0] conflict_cnt;

    logic [DW-1:0] rom_mem [0:63];

    int checks;
    int errors;

    // reference model state
    logic          m_fetch_next;
    logic          m_frv, m_drv, m_derr;
    logic [DW-1:0] m_frd, m_drd;
    logic [CW-1:0] m_cnt;

    inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_flush      (f_flush),
        .f_gnt        (f_gnt),
        .f_rvalid     (f_rvalid),
        .f_rdata      (f_rdata),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .stallreq_if  (stallreq_if),
        .conflict_cnt (conflict_cnt)
    );

    assign rom_inst = rom_ce ? rom_mem[rom_addr[7:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_fetch_next = 1'b1;
        m_frv = 1'b0; m_drv = 1'b0; m_derr = 1'b0;
        m_frd = 32'h0; m_drd = 32'h0; m_cnt = 4'h0;
    endtask

    function automatic void model_grants(output logic fg, output logic dgr, output logic mis);
        logic fe, de;
        fe  = rst_n & f_req & ~f_flush;
        mis = rst_n & d_req & (d_addr[1:0] != 2'b00);
        de  = rst_n & d_req & (d_addr[1:0] == 2'b00);
        if (fe && de) begin
            fg  = m_fetch_next;
            dgr = ~m_fetch_next;
        end else begin
            fg  = fe;
            dgr = de;
        end
    endfunction

    // {f_gnt, d_gnt, rom_ce, rom_addr, stallreq_if}
    function automatic logic [AW+3:0] exp_comb();
        logic fg, dgr, mis;
        logic [AW-1:0] a;
        model_grants(fg, dgr, mis);
        a = fg ? f_addr : (dgr ? d_addr : 32'h0);
        return {fg, dgr | mis, fg | dgr, a, rst_n & f_req & ~fg};
    endfunction

    // advance one clock, updating the model from the inputs seen before the edge
    task automatic tick();
        logic fg, dgr, mis, contest, both;
        logic [DW-1:0] fw, dw;
        model_grants(fg, dgr, mis);
        contest = rst_n & f_req & ~f_flush & d_req & (d_addr[1:0] == 2'b00);
        both    = rst_n & f_req & d_req;
        fw = rom_mem[f_addr[7:2]];
        dw = rom_mem[d_addr[7:2]];
        @(posedge clk);
        if (rst_n) begin
            if (contest) m_fetch_next = ~fg;
            m_frv = fg;
            if (fg) m_frd = fw;
            m_drv  = dgr | mis;
            m_derr = mis;
            if (dgr) m_drd = dw;
            else if (mis) m_drd = 32'h0;
            if (both && m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h0; f_flush = 1'b0;
        d_req = 1'b1; d_addr = 32'h8;
        tick(); tick();
        checks++;
        if ({f_gnt, d_gnt, rom_ce, rom_addr, stallreq_if, f_rvalid, f_rdata,
             d_rvalid, d_rdata, d_err, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b ce=%b addr=%h stall=%b frv=%b drv=%b derr=%b cnt=%0d, all zero required",
                     f_gnt, d_gnt, rom_ce, rom_addr, stallreq_if, f_rvalid, d_rvalid, d_err, conflict_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({f_gnt, d_gnt, rom_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_first_contest: f_gnt=%b d_gnt=%b rom_addr=%h, required 1 0 00000000",
                     f_gnt, d_gnt, rom_addr);
        end
    endtask

    task automatic test_contention();
        logic ef;
        for (int i = 0; i < 6; i++) begin
            f_req = 1'b1; d_req = 1'b1; f_flush = 1'b0;
            f_addr = 32'(i * 8); d_addr = 32'(i * 8 + 4);
            #1;
            ef = (i % 2 == 0);
            checks++;
            if ({f_gnt, d_gnt, stallreq_if, rom_addr} !== {ef, ~ef, ~ef, ef ? f_addr : d_addr}) begin
                errors++;
                $display("FAIL contention_alt[%0d]: f_gnt=%b d_gnt=%b stall=%b addr=%h, required %b %b %b",
                         i, f_gnt, d_gnt, stallreq_if, rom_addr, ef, ~ef, ~ef);
            end
            tick();
            checks++;
            if ({f_rvalid, f_rdata, d_rvalid, d_rdata} !== {m_frv, m_frd, m_drv, m_drd}) begin
                errors++;
                $display("FAIL contention_resp[%0d]: frv=%b frd=%h drv=%b drd=%h, required %b %h %b %h",
                         i, f_rvalid, f_rdata, d_rvalid, d_rdata, m_frv, m_frd, m_drv, m_drd);
            end
        end
        checks++;
        if (conflict_cnt !== 4'd6) begin
            errors++;
            $display("FAIL contention_cnt: got %0d required 6", conflict_cnt);
        end
    endtask

    task automatic test_solo_fetch();
        d_req = 1'b0; f_req = 1'b1; f_flush = 1'b0; f_addr = 32'h4;
        #1;
        checks++;
        if ({f_gnt, rom_ce, rom_addr} !== {1'b1, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL solo_grant: f_gnt=%b ce=%b addr=%h, required 1 1 00000004", f_gnt, rom_ce, rom_addr);
        end
        tick();
        checks++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'h34011100}) begin
            errors++;
            $display("FAIL solo_resp: frv=%b frd=%h, required 1 34011100", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_flush();
        f_req = 1'b1; f_flush = 1'b1; f_addr = 32'h20; d_req = 1'b1; d_addr = 32'h8;
        #1;
        checks++;
        if ({d_gnt, f_gnt, stallreq_if} !== 3'b101) begin
            errors++;
            $display("FAIL flush_grant: d_gnt=%b f_gnt=%b stall=%b, required 1 0 1", d_gnt, f_gnt, stallreq_if);
        end
        tick();
        f_flush = 1'b0;
        checks++;
        if ({f_rvalid, d_rvalid, d_rdata} !== {1'b0, 1'b1, rom_mem[2]}) begin
            errors++;
            $display("FAIL flush_resp: frv=%b drv=%b drd=%h, required 0 1 %h", f_rvalid, d_rvalid, d_rdata, rom_mem[2]);
        end
    endtask

    task automatic test_misaligned();
        f_req = 1'b1; f_flush = 1'b0; f_addr = 32'h10; d_req = 1'b1; d_addr = 32'h6;
        #1;
        checks++;
        if ({f_gnt, d_gnt, rom_addr} !== {1'b1, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL misaligned_grant: f_gnt=%b d_gnt=%b addr=%h, required 1 1 00000010", f_gnt, d_gnt, rom_addr);
        end
        tick();
        checks++;
        if ({d_rvalid, d_err, d_rdata, f_rvalid, f_rdata} !== {1'b1, 1'b1, 32'h0, 1'b1, rom_mem[4]}) begin
            errors++;
            $display("FAIL misaligned_resp: drv=%b derr=%b drd=%h frv=%b frd=%h, required 1 1 0 1 %h",
                     d_rvalid, d_err, d_rdata, f_rvalid, f_rdata, rom_mem[4]);
        end
        d_req = 1'b0; f_req = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic f_hold, d_hold;
        for (int i = 0; i < 400; i++) begin
            #1;
            checks++;
            if ({f_gnt, d_gnt, rom_ce, rom_addr, stallreq_if} !== exp_comb()) begin
                errors++;
                $display("FAIL random_comb[%0d]: got %h required %h", i,
                         {f_gnt, d_gnt, rom_ce, rom_addr, stallreq_if}, exp_comb());
            end
            f_hold = f_req & ~f_gnt;
            d_hold = d_req & ~d_gnt;
            tick();
            checks++;
            if ({f_rvalid, f_rdata, d_rvalid, d_rdata, d_err, conflict_cnt} !==
                {m_frv, m_frd, m_drv, m_drd, m_derr, m_cnt}) begin
                errors++;
                $display("FAIL random_resp[%0d]: frv=%b frd=%h drv=%b drd=%h derr=%b cnt=%0d, required %b %h %b %h %b %0d",
                         i, f_rvalid, f_rdata, d_rvalid, d_rdata, d_err, conflict_cnt,
                         m_frv, m_frd, m_drv, m_drd, m_derr, m_cnt);
            end
            if (!f_hold) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!d_hold) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = {24'h0, 6'($urandom_range(0, 63)),
                          ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            end
            f_flush = ($urandom_range(0, 7) == 0);
        end
        f_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        f_req = 1'b1; f_addr = 32'hC; d_req = 1'b1; d_addr = 32'h8; f_flush = 1'b0;
        tick();
        checks++;
        if ({f_rvalid, f_rdata} !== {m_frv, m_frd} || conflict_cnt !== m_cnt) begin
            errors++;
            $display("FAIL async_pre: frv=%b frd=%h cnt=%0d, required %b %h %0d",
                     f_rvalid, f_rdata, conflict_cnt, m_frv, m_frd, m_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({f_rvalid, d_rvalid, d_err, f_rdata, d_rdata, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: frv=%b drv=%b derr=%b frd=%h drd=%h cnt=%0d, all zero required",
                     f_rvalid, d_rvalid, d_err, f_rdata, d_rdata, conflict_cnt);
        end
        model_reset();
        tick();
        f_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({f_rvalid, d_rvalid, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL async_after: frv=%b drv=%b cnt=%0d, all zero required", f_rvalid, d_rvalid, conflict_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 64; k++) rom_mem[k] = $urandom();
        rom_mem[1] = 32'h34011100;
        rst_n = 1'b0; f_req = 1'b0; f_flush = 1'b0; d_req = 1'b0;
        f_addr = 32'h0; d_addr = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_contention();
        test_solo_fetch();
        test_flush();
        test_misaligned();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
